// File: rtl/seg7_display_ctrl_pkg.sv
// Shared definitions for the 7-segment display controller.
//   reg_sel_e : register select decoded from bus_addr_i[3:2]
//   SEG_BLANK : segment pattern with every segment (and dp) off
//   CTRL_MASK : CTRL bits that are stored; all others read back as 0
package seg7_display_ctrl_pkg;

  typedef enum logic [1:0] {
    REG_DATA = 2'b00,
    REG_CTRL = 2'b01,
    REG_LED  = 2'b10,
    REG_NONE = 2'b11
  } reg_sel_e;

  localparam logic [7:0]  SEG_BLANK = 8'hFF;
  localparam logic [31:0] CTRL_MASK = 32'h00FF_FF01;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to 7-segment decoder, active-low, bit order g..a.
//   nibble : 4-bit hex value
//   seg    : 7-bit segment pattern, 0 = segment lit
module seg7_hex_decode
  import seg7_display_ctrl_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = '1;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = '1;
    endcase
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Memory-mapped 7-segment display / LED output peripheral.
// Registers (word offsets): 0x0 DATA, 0x4 CTRL ([0] enable, [15:8] dp mask,
// [23:16] digit-enable mask), 0x8 LED[15:0], 0xC unmapped.
//   clk, rst    : clock, asynchronous active-high reset
//   bus_ce_i    : transaction select, one transaction per cycle held
//   bus_we_i    : 1 = write, 0 = read
//   bus_addr_i  : byte address, [3:2] picks the register
//   bus_data_i  : write data
//   bus_data_o  : read data, valid with bus_ack_o, else 0
//   bus_ack_o   : one-cycle acknowledge per transaction
//   seg_o       : active-low segments, [7] = dp, [6:0] = g..a
//   an_o        : active-low digit anodes, at most one low
//   led_o       : LED register
module seg7_display_ctrl
  import seg7_display_ctrl_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_ce_i,
  input  logic                  bus_we_i,
  input  logic [3:0]            bus_addr_i,
  input  logic [31:0]           bus_data_i,
  output logic [31:0]           bus_data_o,
  output logic                  bus_ack_o,
  output logic [7:0]            seg_o,
  output logic [NUM_DIGITS-1:0] an_o,
  output logic [15:0]           led_o
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PS_W  = $clog2(SCAN_DIV);

  logic [31:0]           data_q;
  logic [31:0]           ctrl_q;
  logic [15:0]           led_q;
  logic [PS_W-1:0]       presc_q;
  logic [IDX_W-1:0]      idx_q;

  reg_sel_e              sel;
  logic [31:0]           rd_data;
  logic [3:0]            nibble;
  logic [6:0]            hex_seg;
  logic                  lit;
  logic [7:0]            seg_n;
  logic [NUM_DIGITS-1:0] an_n;
  logic                  addr_unused;

  // Byte lanes within a word are not decoded.
  assign addr_unused = ^bus_addr_i[1:0];
  assign sel         = reg_sel_e'(bus_addr_i[3:2]);

  always_comb begin
    rd_data = '0;
    case (sel)
      REG_DATA: rd_data = data_q;
      REG_CTRL: rd_data = ctrl_q;
      REG_LED:  rd_data = {16'h0000, led_q};
      default:  rd_data = '0;
    endcase
  end

  // Register file and bus handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q     <= '0;
      ctrl_q     <= '0;
      led_q      <= '0;
      bus_ack_o  <= 1'b0;
      bus_data_o <= '0;
    end else begin
      bus_ack_o  <= bus_ce_i;
      bus_data_o <= (bus_ce_i && !bus_we_i) ? rd_data : '0;
      if (bus_ce_i && bus_we_i) begin
        case (sel)
          REG_DATA: data_q <= bus_data_i;
          REG_CTRL: ctrl_q <= bus_data_i & CTRL_MASK;
          REG_LED:  led_q  <= bus_data_i[15:0];
          default:  ;
        endcase
      end
    end
  end

  // Scan prescaler and digit index; free-running regardless of enable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else if (presc_q == PS_W'(SCAN_DIV - 1)) begin
      presc_q <= '0;
      idx_q   <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign nibble = 4'(data_q >> {idx_q, 2'b00});

  seg7_hex_decode u_hex_decode (
    .nibble (nibble),
    .seg    (hex_seg)
  );

  always_comb begin
    lit   = ctrl_q[0] && ctrl_q[16 + 32'(idx_q)];
    seg_n = SEG_BLANK;
    an_n  = '1;
    if (lit) begin
      seg_n       = {~ctrl_q[8 + 32'(idx_q)], hex_seg};
      an_n[idx_q] = 1'b0;
    end
  end

  // Registered outputs: the whole pattern is taken from one state snapshot,
  // so a mid-scan DATA write never shows a torn digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_o <= SEG_BLANK;
      an_o  <= '1;
    end else begin
      seg_o <= seg_n;
      an_o  <= an_n;
    end
  end

  assign led_o = led_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
module tb_seg7_display_ctrl;

  localparam int unsigned ND = 8;
  localparam int unsigned SD = 4;

  logic        clk;
  logic        rst;
  logic        bus_ce_i;
  logic        bus_we_i;
  logic [3:0]  bus_addr_i;
  logic [31:0] bus_data_i;
  logic [31:0] bus_data_o;
  logic        bus_ack_o;
  logic [7:0]  seg_o;
  logic [7:0]  an_o;
  logic [15:0] led_o;

  seg7_display_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus_ce_i   (bus_ce_i),
    .bus_we_i   (bus_we_i),
    .bus_addr_i (bus_addr_i),
    .bus_data_i (bus_data_i),
    .bus_data_o (bus_data_o),
    .bus_ack_o  (bus_ack_o),
    .seg_o      (seg_o),
    .an_o       (an_o),
    .led_o      (led_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: register contents plus a count of clock edges since
  // reset release; the scan position follows from that count alone.
  int unsigned k;
  logic [31:0] m_data;
  logic [31:0] m_ctrl;
  logic [15:0] m_led;
  logic [6:0]  hex_tab [16];

  initial begin
    hex_tab[0]  = 7'h40; hex_tab[1]  = 7'h79; hex_tab[2]  = 7'h24; hex_tab[3]  = 7'h30;
    hex_tab[4]  = 7'h19; hex_tab[5]  = 7'h12; hex_tab[6]  = 7'h02; hex_tab[7]  = 7'h78;
    hex_tab[8]  = 7'h00; hex_tab[9]  = 7'h10; hex_tab[10] = 7'h08; hex_tab[11] = 7'h03;
    hex_tab[12] = 7'h46; hex_tab[13] = 7'h21; hex_tab[14] = 7'h06; hex_tab[15] = 7'h0E;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned cur_digit(input int unsigned kk);
    return (kk / SD) % ND;
  endfunction

  function automatic bit digit_lit(input int unsigned kk);
    int unsigned d;
    d = cur_digit(kk);
    return m_ctrl[0] && m_ctrl[16 + d];
  endfunction

  function automatic logic [7:0] exp_seg(input int unsigned kk);
    int unsigned d;
    int unsigned nib;
    d   = cur_digit(kk);
    nib = (m_data / (32'd1 << (4 * d))) % 16;
    if (!digit_lit(kk)) return 8'hFF;
    return {~m_ctrl[8 + d], hex_tab[nib]};
  endfunction

  function automatic logic [7:0] exp_an(input int unsigned kk);
    if (!digit_lit(kk)) return 8'hFF;
    return 8'hFF - 8'(1 << cur_digit(kk));
  endfunction

  function automatic logic [31:0] model_read(input logic [3:0] addr);
    case (addr / 4)
      0: return m_data;
      1: return m_ctrl;
      2: return {16'h0000, m_led};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [3:0] addr, input logic [31:0] wd);
    case (addr / 4)
      0: m_data = wd;
      1: m_ctrl = wd & 32'h00FF_FF01;
      2: m_led  = wd[15:0];
      default: ;
    endcase
  endtask

  task automatic model_reset();
    k = 0; m_data = '0; m_ctrl = '0; m_led = '0;
  endtask

  // One bus cycle: drive at negedge, check just after the following posedge.
  task automatic step(input logic ce, input logic we, input logic [3:0] addr,
                      input logic [31:0] wd);
    logic [7:0]  es;
    logic [7:0]  ea;
    logic [31:0] erd;
    @(negedge clk);
    bus_ce_i = ce; bus_we_i = we; bus_addr_i = addr; bus_data_i = wd;
    es  = exp_seg(k);
    ea  = exp_an(k);
    erd = (ce && !we) ? model_read(addr) : 32'h0;
    @(posedge clk);
    #1;
    check_val("ack", {31'h0, bus_ack_o}, {31'h0, ce});
    check_val("rdata", bus_data_o, erd);
    check_val("seg", {24'h0, seg_o}, {24'h0, es});
    check_val("an", {24'h0, an_o}, {24'h0, ea});
    if (ce && we) model_write(addr, wd);
    k++;
    check_val("led", {16'h0, led_o}, {16'h0, m_led});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ack"}, {31'h0, bus_ack_o}, 32'h0);
    check_val({tag, "_rdata"}, bus_data_o, 32'h0);
    check_val({tag, "_an"}, {24'h0, an_o}, 32'hFF);
    check_val({tag, "_seg"}, {24'h0, seg_o}, 32'hFF);
    check_val({tag, "_led"}, {16'h0, led_o}, 32'h0);
  endtask

  initial begin
    bit found;
    rst = 1'b1;
    bus_ce_i = 1'b0; bus_we_i = 1'b0; bus_addr_i = '0; bus_data_i = '0;
    model_reset();

    // Reset held 195 ns
    #15;
    for (int i = 0; i < 9; i++) begin
      check_reset_outputs("rst_hold");
      #20;
    end
    rst = 1'b0;

    idle(3);

    // Full scan with all digits on
    step(1'b1, 1'b1, 4'h0, 32'h7654_3210);
    step(1'b1, 1'b1, 4'h4, 32'h00FF_0001);
    idle(40);

    // Upper digits blanked, dp on digit 0
    step(1'b1, 1'b1, 4'h4, 32'h000F_0101);
    idle(34);

    // Back-to-back transactions
    step(1'b1, 1'b1, 4'h8, 32'h1234_A5A5);
    step(1'b1, 1'b0, 4'h8, 32'h0);
    step(1'b1, 1'b0, 4'hC, 32'h0);
    check_val("s4_led", {16'h0, led_o}, 32'h0000_A5A5);
    step(1'b1, 1'b0, 4'h4, 32'h0);

    // DATA write while digit 3 is lit, early in its slot
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      if (cur_digit(k) == 3 && (k % SD) == 1) found = 1'b1;
      else step(1'b0, 1'b0, 4'h0, 32'h0);
    end
    check_val("s5_find", {31'h0, found}, 32'h1);
    step(1'b1, 1'b1, 4'h0, 32'hFFFF_FFFF);
    idle(12);

    // Asynchronous reset in the middle of a write
    @(negedge clk);
    bus_ce_i = 1'b1; bus_we_i = 1'b1; bus_addr_i = 4'h0; bus_data_i = $urandom;
    #3 rst = 1'b1;
    #1 check_reset_outputs("s6_async");
    @(posedge clk);
    #1 check_reset_outputs("s6_held");
    @(negedge clk);
    bus_ce_i = 1'b0; bus_we_i = 1'b0;
    @(posedge clk);
    #5 rst = 1'b0;
    model_reset();
    step(1'b1, 1'b0, 4'h0, 32'h0);
    step(1'b1, 1'b1, 4'h4, 32'h00FF_FF01);
    step(1'b1, 1'b1, 4'h0, $urandom);
    idle(34);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic        ce;
      logic        we;
      logic [3:0]  addr;
      logic [31:0] wd;
      ce   = ($urandom_range(0, 3) != 0);
      we   = $urandom_range(0, 1);
      addr = 4'($urandom_range(0, 15));
      wd   = $urandom;
      if (addr[3:2] == 2'b01 && $urandom_range(0, 3) != 0) wd[0] = 1'b1;
      step(ce, we, addr, wd);
    end
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
